// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared constants and types for the GEMM tile sequencer.
// Defaults mirror the systolic array geometry, input buffer depth and bias width.
package gemm_tile_sequencer_pkg;

  localparam int unsigned SYS_ROWS_DEF = 4;   // sys_rows
  localparam int unsigned SYS_COLS_DEF = 2;   // sys_cols
  localparam int unsigned M_TILE_DEF   = 16;  // input_buffer_depth
  localparam int unsigned DIM_W_DEF    = 8;   // bias width

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic [DIM_W_DEF-1:0] m_off;
    logic [DIM_W_DEF-1:0] k_off;
    logic [DIM_W_DEF-1:0] n_off;
    logic [DIM_W_DEF-1:0] m_len;
    logic [DIM_W_DEF-1:0] k_len;
    logic [DIM_W_DEF-1:0] n_len;
    logic                 first_k;
    logic                 last_k;
  } tile_desc_t;

endpackage

// File: rtl/gemm_tile_sequencer_counter.sv
// One tiling dimension: offset register stepping by STEP, clipped length and last flag.
// Counters chain through carry so the inner dimension wraps into the next one.
module tile_dim_counter #(
  parameter int unsigned STEP  = 4,
  parameter int unsigned DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIM_W-1:0] dim,
  output logic [DIM_W-1:0] off,
  output logic [DIM_W-1:0] len,
  output logic             last,
  output logic             carry
);

  localparam logic [DIM_W:0] STEP_W = (DIM_W+1)'(STEP);

  logic [DIM_W:0] remain;
  logic [DIM_W:0] next_off;

  // One extra bit so off+STEP past the dimension never wraps back below it.
  assign remain   = {1'b0, dim} - {1'b0, off};
  assign next_off = {1'b0, off} + STEP_W;
  assign last     = (next_off >= {1'b0, dim});
  assign len      = (remain > STEP_W) ? DIM_W'(STEP) : remain[DIM_W-1:0];
  assign carry    = inc && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off <= '0;
    end else if (clr) begin
      off <= '0;
    end else if (inc) begin
      off <= last ? '0 : next_off[DIM_W-1:0];
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Runtime-configurable GEMM tiling engine: walks an (M,K,N) job as n-outer, m-middle,
// k-inner tiles and hands one descriptor per handshake to the array controller.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int unsigned SYS_ROWS = SYS_ROWS_DEF,
  parameter int unsigned SYS_COLS = SYS_COLS_DEF,
  parameter int unsigned M_TILE   = M_TILE_DEF,
  parameter int unsigned DIM_W    = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic             abort,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] tile_m_off,
  output logic [DIM_W-1:0] tile_k_off,
  output logic [DIM_W-1:0] tile_n_off,
  output logic [DIM_W-1:0] tile_m_len,
  output logic [DIM_W-1:0] tile_k_len,
  output logic [DIM_W-1:0] tile_n_len,
  output logic             tile_first_k,
  output logic             tile_last_k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_state_e state, state_nx;

  logic [DIM_W-1:0] m_dim, k_dim, n_dim;
  logic [DIM_W-1:0] m_off, k_off, n_off;
  logic [DIM_W-1:0] m_len, k_len, n_len;
  logic             m_last, k_last, n_last;
  logic             m_carry, k_carry, n_carry;
  logic             cfg_zero, accept, hs, err_q;
  tile_desc_t       desc;

  assign cfg_zero   = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
  assign accept     = (state == IDLE) && cfg_valid && !cfg_zero;
  assign tile_valid = (state == ISSUE);
  assign hs         = tile_valid && tile_ready;

  tile_dim_counter #(.STEP(SYS_ROWS), .DIM_W(DIM_W)) u_k (
    .clk(clk), .rst_n(rst_n), .clr(accept), .inc(hs), .dim(k_dim),
    .off(k_off), .len(k_len), .last(k_last), .carry(k_carry)
  );

  tile_dim_counter #(.STEP(M_TILE), .DIM_W(DIM_W)) u_m (
    .clk(clk), .rst_n(rst_n), .clr(accept), .inc(k_carry), .dim(m_dim),
    .off(m_off), .len(m_len), .last(m_last), .carry(m_carry)
  );

  tile_dim_counter #(.STEP(SYS_COLS), .DIM_W(DIM_W)) u_n (
    .clk(clk), .rst_n(rst_n), .clr(accept), .inc(m_carry), .dim(n_dim),
    .off(n_off), .len(n_len), .last(n_last), .carry(n_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m_dim <= '0;
      k_dim <= '0;
      n_dim <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= (state == IDLE) && cfg_valid && cfg_zero;
      if (accept) begin
        m_dim <= cfg_m;
        k_dim <= cfg_k;
        n_dim <= cfg_n;
      end
    end
  end

  // Abort wins over the final handshake, so an aborted job never reports done.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE: begin
        if (abort)        state_nx = IDLE;
        else if (n_carry) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Descriptor is zeroed whenever no tile is being offered.
  always_comb begin
    desc = '0;
    if (tile_valid) begin
      desc.m_off   = DIM_W_DEF'(m_off);
      desc.k_off   = DIM_W_DEF'(k_off);
      desc.n_off   = DIM_W_DEF'(n_off);
      desc.m_len   = DIM_W_DEF'(m_len);
      desc.k_len   = DIM_W_DEF'(k_len);
      desc.n_len   = DIM_W_DEF'(n_len);
      desc.first_k = (k_off == '0);
      desc.last_k  = k_last;
    end
  end

  assign tile_m_off   = DIM_W'(desc.m_off);
  assign tile_k_off   = DIM_W'(desc.k_off);
  assign tile_n_off   = DIM_W'(desc.n_off);
  assign tile_m_len   = DIM_W'(desc.m_len);
  assign tile_k_len   = DIM_W'(desc.k_len);
  assign tile_n_len   = DIM_W'(desc.n_len);
  assign tile_first_k = desc.first_k;
  assign tile_last_k  = desc.last_k;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer: directed jobs push expected descriptors,
// a negedge monitor pops and compares on every handshake.
module tb_gemm_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       abort = 1'b0;
  logic       tile_ready = 1'b0;
  logic [7:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
  logic       cfg_ready, tile_valid, tile_first_k, tile_last_k, busy, done, err;
  logic [7:0] tile_m_off, tile_k_off, tile_n_off, tile_m_len, tile_k_len, tile_n_len;

  int         n_vec = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  bit         bp_mode = 1'b0;
  bit         ready_lvl = 1'b0;
  logic [49:0] sb[$];

  always #5 clk = ~clk;

  gemm_tile_sequencer #(
    .SYS_ROWS(4), .SYS_COLS(2), .M_TILE(16), .DIM_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .abort(abort),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_m_off(tile_m_off), .tile_k_off(tile_k_off), .tile_n_off(tile_n_off),
    .tile_m_len(tile_m_len), .tile_k_len(tile_k_len), .tile_n_len(tile_n_len),
    .tile_first_k(tile_first_k), .tile_last_k(tile_last_k),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [49:0] pack(input int mo, input int ko, input int no,
                                       input int ml, input int kl, input int nl,
                                       input bit f, input bit l);
    return {8'(mo), 8'(ko), 8'(no), 8'(ml), 8'(kl), 8'(nl), f, l};
  endfunction

  function automatic logic [49:0] cur();
    return {tile_m_off, tile_k_off, tile_n_off, tile_m_len, tile_k_len, tile_n_len,
            tile_first_k, tile_last_k};
  endfunction

  // Hand-derived tiles of the M=20,K=10,N=3 job; only the first 'limit' are queued.
  task automatic push_big(input int limit);
    int ko[3] = '{0, 4, 8};
    int kl[3] = '{4, 4, 2};
    int mo[2] = '{0, 16};
    int ml[2] = '{16, 4};
    int no[2] = '{0, 2};
    int nl[2] = '{2, 1};
    int cnt = 0;
    for (int ni = 0; ni < 2; ni++)
      for (int mi = 0; mi < 2; mi++)
        for (int ki = 0; ki < 3; ki++) begin
          if (cnt < limit)
            sb.push_back(pack(mo[mi], ko[ki], no[ni], ml[mi], kl[ki], nl[ni], ki == 0, ki == 2));
          cnt++;
        end
  endtask

  task automatic push_small();
    sb.push_back(pack(0, 0, 0, 4, 4, 2, 1'b1, 1'b1));
  endtask

  task automatic start_job(input int m, input int k, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < 50 && !cfg_ready; i++) begin
      @(posedge clk); #1;
    end
    cfg_m = 8'(m); cfg_k = 8'(k); cfg_n = 8'(n);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Ready driver: fixed level or random backpressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      tile_ready = bp_mode ? ($urandom_range(0, 2) != 0) : ready_lvl;
    end
  end

  // Monitor: pop-and-compare on handshakes, hold check while stalled, pulse counters.
  initial begin
    logic [49:0] prev;
    bit stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (tile_valid && stalled) check("stall_hold", 64'(cur()), 64'(prev));
      stalled = 1'b0;
      if (tile_valid && tile_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_tile: got %0h expected none", cur());
        end else begin
          check("tile", 64'(cur()), 64'(sb.pop_front()));
        end
      end else if (tile_valid) begin
        stalled = 1'b1;
        prev = cur();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_tile_valid", 64'(tile_valid), 64'd0);
    check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    check("rst_fields", 64'(cur()), 64'd0);
    rst_n = 1'b1;
    ready_lvl = 1'b1;

    // Single-tile job, exact latency
    push_small();
    start_job(4, 4, 2);
    check("first_latency", 64'(tile_valid), 64'd1);
    check("busy_issue", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("done_pulse", 64'({done, tile_valid, busy}), 64'b101);
    @(posedge clk); #1;
    check("after_done", 64'({done, cfg_ready, busy}), 64'b010);
    check("small_drained", 64'(sb.size()), 64'd0);

    // 12-tile job, ready tied high
    push_big(12);
    start_job(20, 10, 3);
    wait_done(100);

    // Same job with random backpressure
    bp_mode = 1'b1;
    push_big(12);
    start_job(20, 10, 3);
    wait_done(400);
    bp_mode = 1'b0;

    // Zero dimension rejected
    @(posedge clk); #1;
    cfg_m = 8'd5; cfg_k = 8'd0; cfg_n = 8'd5;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("err_pulse", 64'({err, cfg_ready, tile_valid}), 64'b110);
    @(posedge clk); #1;
    check("err_clear", 64'({err, cfg_ready, tile_valid}), 64'b010);
    push_small();
    start_job(4, 4, 2);
    wait_done(20);
    check("err_count", 64'(err_cnt), 64'd1);

    // Abort on the fifth tile; that tile's handshake still counts
    d0 = done_cnt;
    push_big(5);
    start_job(20, 10, 3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tile_valid && tile_m_off == 8'd16 && tile_k_off == 8'd4) break;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_state", 64'({tile_valid, cfg_ready, busy, done}), 64'b0100);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_drained", 64'(sb.size()), 64'd0);
    push_small();
    start_job(4, 4, 2);
    wait_done(20);

    // Asynchronous reset while stalled in ISSUE
    ready_lvl = 1'b0;
    start_job(20, 10, 3);
    repeat (2) @(posedge clk);
    #2;
    check("stalled_valid", 64'(tile_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 64'({tile_valid, cfg_ready, busy, done, err}), 64'b01000);
    check("arst_fields", 64'(cur()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_lvl = 1'b1;
    push_small();
    start_job(4, 4, 2);
    wait_done(20);

    check("done_total", 64'(done_cnt), 64'd6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
